// File: rtl/complex_mac_pkg.sv
// rtl/complex_mac_pkg.sv - shared state codes, product order and defaults for complex_mac
package complex_mac_pkg;

    localparam int ACC_W_DEF   = 12;
    localparam int TIMEOUT_DEF = 64;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_ACC       = 3'd4;
    localparam logic [2:0] S_COMMIT    = 3'd5;

    // x_imag/y_imag pick the imaginary part of each operand, to_im steers the product, sub negates it
    typedef struct packed {
        logic x_imag;
        logic y_imag;
        logic to_im;
        logic sub;
    } prod_op_t;

    localparam prod_op_t PROD_AC = 4'b0000;
    localparam prod_op_t PROD_BD = 4'b1101;
    localparam prod_op_t PROD_AD = 4'b0110;
    localparam prod_op_t PROD_BC = 4'b1010;

    function automatic prod_op_t prod_op(input logic [1:0] idx);
        case (idx)
            2'd0:    return PROD_AC;
            2'd1:    return PROD_BD;
            2'd2:    return PROD_AD;
            default: return PROD_BC;
        endcase
    endfunction

endpackage

// File: rtl/cmac_acc.sv
// rtl/cmac_acc.sv - working and committed real/imaginary accumulator pair
module cmac_acc
    import complex_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ACC_W-1:0] addend,
    input  logic                    add_en,
    input  logic                    to_im,
    input  logic                    sub,
    input  logic                    load,
    input  logic                    clear,
    input  logic                    commit,
    output logic signed [ACC_W-1:0] acc_re,
    output logic signed [ACC_W-1:0] acc_im
);

    logic signed [ACC_W-1:0] work_re;
    logic signed [ACC_W-1:0] work_im;
    logic signed [ACC_W-1:0] delta;

    assign delta = sub ? -addend : addend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_re  <= '0;
            acc_im  <= '0;
            work_re <= '0;
            work_im <= '0;
        end else begin
            if (clear) begin
                acc_re <= '0;
                acc_im <= '0;
            end else if (commit) begin
                acc_re <= work_re;
                acc_im <= work_im;
            end
            // a clear on the same edge as load restarts the sum from zero
            if (load) begin
                work_re <= clear ? '0 : acc_re;
                work_im <= clear ? '0 : acc_im;
            end else if (add_en) begin
                if (to_im) begin
                    work_im <= work_im + delta;
                end else begin
                    work_re <= work_re + delta;
                end
            end
        end
    end

endmodule

// File: rtl/complex_mac.sv
// rtl/complex_mac.sv - complex multiply-accumulate sequencer driving a shared 4x4 multiplier
module complex_mac
    import complex_mac_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clr,
    input  logic [3:0]              x,
    input  logic [3:0]              y,
    output logic                    mul_start,
    output logic [3:0]              mul_a,
    output logic [3:0]              mul_b,
    input  logic                    mul_done,
    input  logic [7:0]              mul_p,
    output logic signed [ACC_W-1:0] acc_re,
    output logic signed [ACC_W-1:0] acc_im,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int PW = (ACC_W > 8) ? ACC_W : 8;

    logic [2:0]              state;
    logic [1:0]              idx;
    logic [CW-1:0]           cnt;
    logic [3:0]              x_q;
    logic [3:0]              y_q;
    logic                    timed_out;
    prod_op_t                op;
    logic [PW-1:0]           p_wide;
    logic signed [ACC_W-1:0] addend;

    // operands come from latched inputs and idx, so they hold from ISSUE through ACC
    assign op        = prod_op(idx);
    assign mul_a     = {2'b00, op.x_imag ? x_q[1:0] : x_q[3:2]};
    assign mul_b     = {2'b00, op.y_imag ? y_q[1:0] : y_q[3:2]};
    assign mul_start = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_COMMIT);
    assign timed_out = (cnt == CW'(TIMEOUT - 1));
    assign p_wide    = PW'(signed'(mul_p));
    assign addend    = p_wide[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            idx   <= 2'd0;
            cnt   <= '0;
            x_q   <= 4'd0;
            y_q   <= 4'd0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_q   <= x;
                        y_q   <= y;
                        idx   <= 2'd0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!mul_done) begin
                        cnt   <= '0;
                        state <= S_WAIT_DONE;
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (mul_done) begin
                        state <= S_ACC;
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ACC: begin
                    if (idx == 2'd3) begin
                        state <= S_COMMIT;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= S_ISSUE;
                    end
                end
                S_COMMIT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    cmac_acc #(.ACC_W(ACC_W)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .addend (addend),
        .add_en (state == S_ACC),
        .to_im  (op.to_im),
        .sub    (op.sub),
        .load   ((state == S_IDLE) && start),
        .clear  ((state == S_IDLE) && clr),
        .commit (state == S_COMMIT),
        .acc_re (acc_re),
        .acc_im (acc_im)
    );

endmodule

// File: tb/tb_complex_mac.sv
// tb/tb_complex_mac.sv - self-checking bench for complex_mac at two accumulator widths
module tb_complex_mac;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] x = 4'd0;
    logic [3:0] y = 4'd0;
    logic       stuck = 1'b0;

    logic              mul_start_a, mul_done_a, busy_a, done_a, err_a;
    logic [3:0]        mul_a_a, mul_b_a;
    logic [7:0]        mul_p_a;
    logic signed [11:0] acc_re_a, acc_im_a;

    logic              mul_start_b, mul_done_b, busy_b, done_b, err_b;
    logic [3:0]        mul_a_b, mul_b_b;
    logic [7:0]        mul_p_b;
    logic signed [5:0] acc_re_b, acc_im_b;

    int total = 0;
    int bad = 0;
    int mre = 0;
    int mim = 0;
    int n_done_a = 0;
    int n_err_a = 0;
    int n_start_a = 0;
    int unstable = 0;
    logic [7:0] pairs[$];

    always #5 clk = ~clk;

    complex_mac #(.ACC_W(12), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .x(x), .y(y),
        .mul_start(mul_start_a), .mul_a(mul_a_a), .mul_b(mul_b_a),
        .mul_done(mul_done_a), .mul_p(mul_p_a),
        .acc_re(acc_re_a), .acc_im(acc_im_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    complex_mac #(.ACC_W(6), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .x(x), .y(y),
        .mul_start(mul_start_b), .mul_a(mul_a_b), .mul_b(mul_b_b),
        .mul_done(mul_done_b), .mul_p(mul_p_b),
        .acc_re(acc_re_b), .acc_im(acc_im_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    // behavioural multipliers: accept a request, drop done, return the product 3 cycles later
    logic       mbusy_a, mbusy_b;
    logic [1:0] mcnt_a, mcnt_b;
    logic [3:0] la_a, lb_a, la_b, lb_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_done_a <= 1'b1; mbusy_a <= 1'b0; mul_p_a <= 8'd0;
            mcnt_a <= 2'd0; la_a <= 4'd0; lb_a <= 4'd0;
        end else if (mbusy_a) begin
            if (mcnt_a == 2'd0) begin
                mbusy_a <= 1'b0; mul_done_a <= 1'b1; mul_p_a <= 8'(la_a) * 8'(lb_a);
            end else begin
                mcnt_a <= mcnt_a - 2'd1;
            end
        end else if (mul_start_a && !stuck) begin
            mbusy_a <= 1'b1; mul_done_a <= 1'b0; la_a <= mul_a_a; lb_a <= mul_b_a; mcnt_a <= 2'd2;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_done_b <= 1'b1; mbusy_b <= 1'b0; mul_p_b <= 8'd0;
            mcnt_b <= 2'd0; la_b <= 4'd0; lb_b <= 4'd0;
        end else if (mbusy_b) begin
            if (mcnt_b == 2'd0) begin
                mbusy_b <= 1'b0; mul_done_b <= 1'b1; mul_p_b <= 8'(la_b) * 8'(lb_b);
            end else begin
                mcnt_b <= mcnt_b - 2'd1;
            end
        end else if (mul_start_b && !stuck) begin
            mbusy_b <= 1'b1; mul_done_b <= 1'b0; la_b <= mul_a_b; lb_b <= mul_b_b; mcnt_b <= 2'd2;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (done_a) n_done_a++;
            if (err_a) n_err_a++;
            if (mul_start_a) begin
                n_start_a++;
                pairs.push_back({mul_a_a, mul_b_a});
            end
            if (!mul_done_a && (mul_a_a !== la_a || mul_b_a !== lb_a)) unstable++;
        end
    end

    function automatic int wrap(input int v, input int w);
        int m;
        m = v & ((1 << w) - 1);
        if (m >= (1 << (w - 1))) m -= (1 << w);
        return m;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_acc(input string tag);
        check({tag, "_re12"}, int'(acc_re_a), wrap(mre, 12));
        check({tag, "_im12"}, int'(acc_im_a), wrap(mim, 12));
        check({tag, "_re6"}, int'(acc_re_b), wrap(mre, 6));
        check({tag, "_im6"}, int'(acc_im_b), wrap(mim, 6));
    endtask

    task automatic txn(input string tag, input logic [3:0] xv, input logic [3:0] yv,
                       input logic cl, input bit poke);
        int a, b, c, d, cyc, d0, s0;
        logic [31:0] exp_pairs, obs_pairs;
        a = int'(xv[3:2]); b = int'(xv[1:0]); c = int'(yv[3:2]); d = int'(yv[1:0]);
        d0 = n_done_a; s0 = n_start_a; pairs.delete();
        start = 1'b1; clr = cl; x = xv; y = yv;
        @(negedge clk);
        start = 1'b0; clr = 1'b0; cyc = 0;
        while (!done_a && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 5) begin
                start = 1'b1; clr = 1'b1; x = 4'hF; y = 4'hF;
            end else begin
                start = 1'b0; clr = 1'b0;
            end
        end
        check({tag, "_wait"}, int'(cyc < 200), 1);
        @(negedge clk);
        if (cl) begin mre = 0; mim = 0; end
        mre += a * c - b * d;
        mim += a * d + b * c;
        check_acc(tag);
        check({tag, "_ndone"}, n_done_a - d0, 1);
        check({tag, "_nstart"}, n_start_a - s0, 4);
        exp_pairs = {2'b00, xv[3:2], 2'b00, yv[3:2], 2'b00, xv[1:0], 2'b00, yv[1:0],
                     2'b00, xv[3:2], 2'b00, yv[1:0], 2'b00, xv[1:0], 2'b00, yv[3:2]};
        obs_pairs = (pairs.size() == 4) ? {pairs[0], pairs[1], pairs[2], pairs[3]} : 32'hFFFF_FFFF;
        check({tag, "_pairs"}, int'(obs_pairs), int'(exp_pairs));
    endtask

    initial begin
        logic [3:0] rx, ry;
        int n, d0, e0;

        repeat (2) @(negedge clk);
        check("rst_acc_a", int'({acc_re_a, acc_im_a}), 0);
        check("rst_ctl_a", int'({busy_a, done_a, err_a, mul_start_a, mul_a_a, mul_b_a}), 0);
        check("rst_all_b", int'({acc_re_b, acc_im_b, busy_b, done_b, err_b, mul_start_b, mul_a_b, mul_b_b}), 0);
        rst = 1'b1;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        txn("t1", 4'b1010, 4'b0110, 1'b0, 1'b0);
        check("t1_re_lit", int'(acc_re_a), -2);
        check("t1_im_lit", int'(acc_im_a), 6);
        txn("t2", 4'b1011, 4'b1001, 1'b0, 1'b0);
        txn("t3", 4'b0100, 4'b0111, 1'b0, 1'b0);
        check("t3_re_lit", int'(acc_re_a), 0);
        check("t3_im_lit", int'(acc_im_a), 17);
        txn("t4", 4'hF, 4'hF, 1'b1, 1'b0);
        check("t4_im_lit", int'(acc_im_a), 18);

        for (int i = 0; i < 8; i++) begin
            rx = 4'($urandom);
            ry = 4'($urandom);
            txn("rnd", rx, ry, ($urandom_range(0, 3) == 0), 1'b0);
        end

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mre = 0; mim = 0;
        @(negedge clk);
        check_acc("clr");
        txn("t5", 4'b1110, 4'b0111, 1'b0, 1'b0);

        stuck = 1'b1;
        d0 = n_done_a; e0 = n_err_a;
        start = 1'b1; x = 4'hF; y = 4'hF;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("to_busy_cycles", n, 9);
        check("to_err_a", int'(err_a), 1);
        check("to_err_b", int'(err_b), 1);
        @(negedge clk);
        check("to_err_pulse", int'(err_a), 0);
        check("to_nerr", n_err_a - e0, 1);
        check("to_ndone", n_done_a - d0, 0);
        check_acc("to");
        stuck = 1'b0;

        start = 1'b1; x = 4'hF; y = 4'hF;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_acc_a", int'({acc_re_a, acc_im_a}), 0);
        check("arst_ctl_a", int'({busy_a, done_a, err_a, mul_start_a, mul_a_a, mul_b_a}), 0);
        check("arst_all_b", int'({acc_re_b, acc_im_b, busy_b, done_b, err_b, mul_start_b, mul_a_b, mul_b_b}), 0);
        mre = 0; mim = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        txn("post_rst", 4'b1010, 4'b0110, 1'b0, 1'b0);
        check("post_rst_re_lit", int'(acc_re_a), -2);
        check("post_rst_im_lit", int'(acc_im_a), 6);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mre = 0; mim = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            txn("wrap", 4'b1100, 4'b1100, 1'b0, (i == 1));
        end
        check("wrap_re6_lit", int'(acc_re_b), -28);
        check("wrap_re12_lit", int'(acc_re_a), 36);
        repeat (3) @(negedge clk);
        check("poke_idle", int'(busy_a), 0);
        check("stable", unstable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
